// File: rtl/dmac_evt_pkg.sv
// dmac_evt_pkg: shared sizes, line indices and types for the termination event collector.
package dmac_evt_pkg;
  localparam int NB_CORES = 8;
  localparam int CNT_WIDTH = 3;
  localparam int NB_LINES = NB_CORES + 2;
  localparam int LINE_CL = NB_CORES;
  localparam int LINE_PE = NB_CORES + 1;
  typedef enum logic {EVT = 1'b0, IRQ = 1'b1} evt_class_e;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/dmac_evt_cnt.sv
// dmac_evt_cnt: saturating pending counter with ack, level request and sticky overflow.
module dmac_evt_cnt
  import dmac_evt_pkg::*;
#(
  parameter int CNT_WIDTH = dmac_evt_pkg::CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic ack,
  input  logic ovf_clr,
  output logic req,
  output logic ovf
);
  logic [CNT_WIDTH-1:0] cnt;
  logic dec, sat;
  assign req = |cnt;
  assign sat = &cnt;
  assign dec = ack & req;
  // pulse and ack together cancel, so a saturated line taking both never overflows
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (inc & !dec & !sat) cnt <= cnt + 1'b1;
      else if (!inc & dec) cnt <= cnt - 1'b1;
      ovf <= (inc & !dec & sat) | (ovf & !ovf_clr);
    end
endmodule

// File: rtl/dmac_term_evt_collector.sv
// dmac_term_evt_collector: holds DMA termination pulses as pending counts and
// presents them as masked level requests with per-line ack and overflow flags.
module dmac_term_evt_collector
  import dmac_evt_pkg::*;
#(
  parameter int NB_CORES = dmac_evt_pkg::NB_CORES,
  parameter int CNT_WIDTH = dmac_evt_pkg::CNT_WIDTH,
  localparam int NL = NB_CORES + 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NL-1:0]   i_term_evt,
  input  logic [NL-1:0]   i_term_irq,
  input  logic [NL-1:0]   i_mask,
  output logic [NL-1:0]   o_evt_req,
  input  logic [NL-1:0]   i_evt_ack,
  output logic [NL-1:0]   o_irq_req,
  input  logic [NL-1:0]   i_irq_ack,
  output logic [2*NL-1:0] o_ovf,
  input  logic            i_ovf_clr,
  output logic            o_pending
);
  logic [1:0][NL-1:0] pulse, ack, raw, ovf;
  assign pulse = {i_term_irq, i_term_evt};
  assign ack = {i_irq_ack, i_evt_ack};
  for (genvar c = 0; c < 2; c++) begin : g_cls
    for (genvar i = 0; i < NL; i++) begin : g_line
      dmac_evt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk(i_clk),
        .rst(i_rst),
        .inc(pulse[c][i]),
        .ack(ack[c][i]),
        .ovf_clr(i_ovf_clr),
        .req(raw[c][i]),
        .ovf(ovf[c][i])
      );
    end
  end
  // masking only gates the request; counting and pending ignore it
  assign o_evt_req = raw[EVT] & ~i_mask;
  assign o_irq_req = raw[IRQ] & ~i_mask;
  assign o_ovf = ovf;
  assign o_pending = |raw;
endmodule
